// File: rtl/ctrl_decode_pkg.sv
// ctrl_decode_pkg: RV32 opcodes, ALU op codes, control word type and decode function (M-ext via CTRL_DECODE_MEXT_EN)
package ctrl_decode_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_MEXT  = 7'b0000001;
  localparam logic [3:0] ALUOP_R     = 4'b0000;
  localparam logic [3:0] ALUOP_IMM   = 4'b0001;
  localparam logic [3:0] ALUOP_BR    = 4'b0010;
  localparam logic [3:0] ALUOP_JUMP  = 4'b0011;
  localparam logic [3:0] ALUOP_LOAD  = 4'b0100;
  localparam logic [3:0] ALUOP_STORE = 4'b0101;
  localparam logic [3:0] ALUOP_LUI   = 4'b0110;
  localparam logic [3:0] ALUOP_AUIPC = 4'b0111;
  localparam logic [3:0] ALUOP_MUL   = 4'b1000;
  typedef struct packed {
    logic       regwrite;
    logic       memrd;
    logic       memw;
    logic       memtoreg;
    logic       branch;
    logic       op_b_sel;
    logic [3:0] aluop;
    logic [1:0] op_a_sel;
    logic [1:0] extend_sel;
    logic [1:0] next_pc_sel;
  } ctrl_t;
  typedef struct packed {
    ctrl_t      ctl;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_word_t;
  function automatic ctrl_word_t decode_ctrl(input logic [31:0] instr);
    ctrl_word_t w;
    w = '0;
    w.illegal = 1'b1;
    w.rd = instr[11:7];
    w.rs1 = instr[19:15];
    w.rs2 = instr[24:20];
    case (instr[6:0])
      OP_R:
`ifdef CTRL_DECODE_MEXT_EN
        {w.illegal, w.ctl} = {1'b0, 6'b100000, instr[31:25] == F7_MEXT ? ALUOP_MUL : ALUOP_R, 6'b000000};
`else
        if (instr[31:25] != F7_MEXT) {w.illegal, w.ctl} = {1'b0, 6'b100000, ALUOP_R, 6'b000000};
`endif
      OP_LOAD:  {w.illegal, w.ctl} = {1'b0, 6'b110101, ALUOP_LOAD,  6'b000000};
      OP_STORE: {w.illegal, w.ctl} = {1'b0, 6'b001001, ALUOP_STORE, 6'b001000};
      OP_BR:    {w.illegal, w.ctl} = {1'b0, 6'b000010, ALUOP_BR,    6'b000001};
      OP_I:     {w.illegal, w.ctl} = {1'b0, 6'b100001, ALUOP_IMM,   6'b000000};
      OP_JALR:  {w.illegal, w.ctl} = {1'b0, 6'b100000, ALUOP_JUMP,  6'b100011};
      OP_JAL:   {w.illegal, w.ctl} = {1'b0, 6'b100000, ALUOP_JUMP,  6'b100010};
      OP_LUI:   {w.illegal, w.ctl} = {1'b0, 6'b100001, ALUOP_LUI,   6'b110100};
      OP_AUIPC: {w.illegal, w.ctl} = {1'b0, 6'b100001, ALUOP_AUIPC, 6'b010100};
      default: ;
    endcase
    return w;
  endfunction
endpackage

// File: rtl/ctrl_fifo.sv
// ctrl_fifo: synchronous FIFO of any DEPTH with flush, registered ready and zeroed head when empty
module ctrl_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic push, pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign pop_valid = count != '0;
  assign pop_data = pop_valid ? mem[rd_ptr] : '0;
  always_comb begin
    push = push_valid && push_ready && !flush;
    pop = pop_valid && pop_ready && !flush;
    count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      push_ready <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_nxt;
      push_ready <= count_nxt < CW'(DEPTH);
      wr_ptr <= flush ? '0 : push ? wrap_inc(wr_ptr) : wr_ptr;
      rd_ptr <= flush ? '0 : pop ? wrap_inc(rd_ptr) : rd_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered RV32 control decoder feeding a DEPTH-entry FIFO (M-ext MUL decode via CTRL_DECODE_MEXT_EN)
module ctrl_decode_pipe
  import ctrl_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int ALUOP_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    instr_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic               memw_o,
  output logic               branch_o,
  output logic               memrd_o,
  output logic               regwrite_o,
  output logic               memtoreg_o,
  output logic               opBsel_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [1:0]         opAsel_o,
  output logic [1:0]         extendsel_o,
  output logic [1:0]         nextPCsel_o,
  output logic               illegal_o
);
  typedef struct packed {
    ctrl_word_t      c;
    logic [XLEN-1:0] pc;
  } entry_t;
  entry_t in_entry, head;
  assign in_entry = '{c: decode_ctrl(instr_i[31:0]), pc: pc_i};
  ctrl_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .push_valid(in_valid_i),
    .push_ready(in_ready_o),
    .push_data (in_entry),
    .pop_valid (out_valid_o),
    .pop_ready (out_ready_i),
    .pop_data  (head)
  );
  assign pc_o = head.pc;
  assign rd_o = head.c.rd;
  assign rs1_o = head.c.rs1;
  assign rs2_o = head.c.rs2;
  assign illegal_o = head.c.illegal;
  assign regwrite_o = head.c.ctl.regwrite;
  assign memrd_o = head.c.ctl.memrd;
  assign memw_o = head.c.ctl.memw;
  assign memtoreg_o = head.c.ctl.memtoreg;
  assign branch_o = head.c.ctl.branch;
  assign opBsel_o = head.c.ctl.op_b_sel;
  assign aluop_o = ALUOP_W'(head.c.ctl.aluop);
  assign opAsel_o = head.c.ctl.op_a_sel;
  assign extendsel_o = head.c.ctl.extend_sel;
  assign nextPCsel_o = head.c.ctl.next_pc_sel;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: scoreboard bench for ctrl_decode_pipe (honours CTRL_DECODE_MEXT_EN)
module tb_ctrl_decode_pipe;
  logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [31:0] instr_i = '0, pc_i = '0;
  logic in_ready_o, out_valid_o, memw_o, branch_o, memrd_o, regwrite_o, memtoreg_o, opBsel_o, illegal_o;
  logic [31:0] pc_o;
  logic [4:0] rd_o, rs1_o, rs2_o;
  logic [3:0] aluop_o;
  logic [1:0] opAsel_o, extendsel_o, nextPCsel_o;
  logic [63:0] got;
  logic [63:0] sb[$];
  int vectors = 0, errs = 0;
`ifdef CTRL_DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  ctrl_decode_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .memw_o(memw_o), .branch_o(branch_o), .memrd_o(memrd_o),
    .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o), .opBsel_o(opBsel_o), .aluop_o(aluop_o),
    .opAsel_o(opAsel_o), .extendsel_o(extendsel_o), .nextPCsel_o(nextPCsel_o), .illegal_o(illegal_o)
  );
  assign got = {illegal_o, regwrite_o, memrd_o, memw_o, memtoreg_o, branch_o, opBsel_o, aluop_o,
                opAsel_o, extendsel_o, nextPCsel_o, rd_o, rs1_o, rs2_o, pc_o};
  always #5 clk_i = ~clk_i;
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [31:0] pc);
    logic [15:0] c;
    logic ill;
    ill = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        if (ins[31:25] == 7'b0000001) begin
          c = MEXT ? 16'b100000_1000_00_00_00 : 16'b0;
          ill = !MEXT;
        end else c = 16'b100000_0000_00_00_00;
      end
      7'b0000011: c = 16'b110101_0100_00_00_00;
      7'b0100011: c = 16'b001001_0101_00_10_00;
      7'b1100011: c = 16'b000010_0010_00_00_01;
      7'b0010011: c = 16'b100001_0001_00_00_00;
      7'b1100111: c = 16'b100000_0011_10_00_11;
      7'b1101111: c = 16'b100000_0011_10_00_10;
      7'b0110111: c = 16'b100001_0110_11_01_00;
      7'b0010111: c = 16'b100001_0111_01_01_00;
      default: begin
        c = 16'b0;
        ill = 1'b1;
      end
    endcase
    return {ill, c, ins[11:7], ins[19:15], ins[24:20], pc};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic [31:0] ins);
    logic [31:0] r;
    r = $urandom();
    in_valid_i = 1'b1;
    instr_i = ins;
    pc_i = {r[31:2], 2'b00};
  endtask
  function automatic logic [31:0] rand_instr(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], op};
  endfunction
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (flush_i) sb.delete();
      else begin
        if (out_valid_o && out_ready_i) begin
          check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) check("sb_head", got, sb.pop_front());
        end
        if (in_valid_i && in_ready_o) sb.push_back(model(instr_i, pc_i));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [6:0] ops [9];
    logic [31:0] a;
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
            7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};
    cyc();
    cyc();
    @(negedge clk_i);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_head", got, 64'd0);
    cyc();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(rand_instr(ops[i]));
      cyc();
      in_valid_i = 1'b0;
      @(negedge clk_i);
      check("latency", 64'(out_valid_o), 64'd1);
      check("legal", 64'(illegal_o), 64'd0);
      cyc();
    end
    drive(32'h0000007F);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("ill_flag", 64'(illegal_o), 64'd1);
    check("ill_rd", 64'(rd_o), 64'd0);
    check("ill_ctrl", 64'(got[62:47]), 64'd0);
    cyc();
    drive(32'h02208033);
    cyc();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("mul_ill", 64'(illegal_o), MEXT ? 64'd0 : 64'd1);
    check("mul_aluop", 64'(aluop_o), MEXT ? 64'd8 : 64'd0);
    cyc();
    out_ready_i = 1'b0;
    a = rand_instr(7'b0110011) & 32'h01FF_FFFF;
    drive(a);
    cyc();
    drive(rand_instr(7'b0110011) & 32'h01FF_FFFF);
    cyc();
    drive(rand_instr(7'b0110011) & 32'h01FF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("full_ready", 64'(in_ready_o), 64'd0);
      check("full_valid", 64'(out_valid_o), 64'd1);
      check("hold_rd", 64'(rd_o), 64'(a[11:7]));
      cyc();
    end
    out_ready_i = 1'b1;
    cyc();
    cyc();
    in_valid_i = 1'b0;
    repeat (3) cyc();
    check("drain3", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
    drive(rand_instr(7'b0000011));
    cyc();
    drive(rand_instr(7'b0100011));
    cyc();
    drive(rand_instr(7'b0010011));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    check("flush_ready", 64'(in_ready_o), 64'd1);
    drive(rand_instr(7'b1101111));
    cyc();
    drive(rand_instr(7'b0110111));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("flush_push_drop", 64'(out_valid_o), 64'd0);
      cyc();
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(rand_instr(ops[$urandom_range(0, 8)]));
      if (i > 0) begin
        @(negedge clk_i);
        check("pp_valid", 64'(out_valid_o), 64'd1);
        check("pp_ready", 64'(in_ready_o), 64'd1);
      end
      cyc();
    end
    in_valid_i = 1'b0;
    repeat (4) cyc();
    @(negedge clk_i);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("end_valid", 64'(out_valid_o), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
